// File: rtl/four_parity_pkg.sv
// Shared definitions for the four-bit even-parity serial link (rx and tx sides).
package four_parity_pkg;

  localparam int unsigned DATA_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_t;

  // Returns 1 when data plus parity bit has odd weight (even-parity violation).
  function automatic logic parityErr(input logic [DATA_BITS-1:0] data, input logic parBit);
    return (^data) ^ parBit;
  endfunction

endpackage

// File: rtl/four_parity_rx_bit_timer.sv
// Bit timer: loadable down-counter that reloads itself after reaching zero.
// expire is high in every cycle the count is zero.
module bit_timer #(
  parameter int unsigned          WIDTH  = 2,
  parameter logic [WIDTH-1:0]     RELOAD = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Count down, reload at zero; an explicit load takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/four_parity_rx.sv
// Four-bit even-parity serial receiver: start, D0..D3 (LSB first), parity, stop.
// Optional macro FOUR_PARITY_RX_ERRCNT_EN adds outErrCnt, a saturating count of
// frames flagged with a parity or stop-bit error.
module four_parity_rx
  import four_parity_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inS,
  output logic [DATA_BITS-1:0] outData,
  output logic                 outValid,
  output logic                 outErr,
  output logic                 outFrameErr,
  output logic                 outBusy
`ifdef FOUR_PARITY_RX_ERRCNT_EN
  ,
  output logic [7:0]           outErrCnt
`endif
);

  localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  if ((CLKS_PER_BIT < 2) || ((CLKS_PER_BIT % 2) != 0)) begin : gBadClksPerBit
    $error("four_parity_rx: CLKS_PER_BIT must be even and at least 2");
  end

  rxState_t             state;
  rxState_t             nextState;
  logic                 syncQ1;
  logic                 inSS;
  logic                 armed;
  logic [DATA_BITS-1:0] shiftReg;
  logic [BW-1:0]        bitCnt;
  logic                 parBit;
  logic                 timerLoad;
  logic [TW-1:0]        timerVal;
  logic                 expire;
  logic                 shiftEn;
  logic                 parEn;
  logic                 stopEn;

  bit_timer #(
    .WIDTH  (TW),
    .RELOAD (FULL_LOAD)
  ) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timerLoad),
    .loadVal (timerVal),
    .expire  (expire)
  );

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncQ1 <= 1'b1;
      inSS   <= 1'b1;
    end else begin
      syncQ1 <= inS;
      inSS   <= syncQ1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode plus timer load and sampling strobes.
  always_comb begin
    nextState = state;
    timerLoad = 1'b0;
    timerVal  = FULL_LOAD;
    shiftEn   = 1'b0;
    parEn     = 1'b0;
    stopEn    = 1'b0;
    outBusy   = (state != IDLE);
    case (state)
      IDLE: begin
        if (armed && !inSS) begin
          nextState = START;
          timerLoad = 1'b1;
          timerVal  = HALF_LOAD;
        end
      end
      START: begin
        if (expire) begin
          if (inSS) begin
            nextState = IDLE;
          end else begin
            nextState = DATA;
            timerLoad = 1'b1;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shiftEn = 1'b1;
          if (bitCnt == LAST_BIT) begin
            nextState = PARITY;
          end
        end
      end
      PARITY: begin
        if (expire) begin
          parEn     = 1'b1;
          nextState = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          stopEn    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Sample data/parity/stop bits, publish results, and manage the armed flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed       <= 1'b1;
      shiftReg    <= '0;
      bitCnt      <= '0;
      parBit      <= 1'b0;
      outData     <= '0;
      outValid    <= 1'b0;
      outErr      <= 1'b0;
      outFrameErr <= 1'b0;
    end else begin
      outValid <= stopEn;
      if (state == IDLE) begin
        bitCnt <= '0;
        if (inSS) begin
          armed <= 1'b1;
        end
      end
      if (shiftEn) begin
        shiftReg <= {inSS, shiftReg[DATA_BITS-1:1]};
        bitCnt   <= bitCnt + BW'(1);
      end
      if (parEn) begin
        parBit <= inSS;
      end
      if (stopEn) begin
        outData     <= shiftReg;
        outErr      <= parityErr(shiftReg, parBit);
        outFrameErr <= ~inSS;
        // A low stop bit means a break: stay disarmed until the line goes high.
        if (!inSS) begin
          armed <= 1'b0;
        end
      end
    end
  end

`ifdef FOUR_PARITY_RX_ERRCNT_EN
  // Saturating count of errored frames, updated alongside outValid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outErrCnt <= '0;
    end else if (stopEn && (parityErr(shiftReg, parBit) || !inSS) && (outErrCnt != '1)) begin
      outErrCnt <= outErrCnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_four_parity_rx.sv
// Directed self-checking bench for four_parity_rx with CLKS_PER_BIT=4.
module tb_four_parity_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inS = 1'b1;
  logic [3:0] outData;
  logic       outValid;
  logic       outErr;
  logic       outFrameErr;
  logic       outBusy;
`ifdef FOUR_PARITY_RX_ERRCNT_EN
  logic [7:0] outErrCnt;
`endif

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails = 0;
  int unsigned cycleCnt = 0;
  int unsigned validCount = 0;
  int unsigned lastValidCycle = 0;
  int unsigned frameStart = 0;

  four_parity_rx #(
    .CLKS_PER_BIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inS         (inS),
    .outData     (outData),
    .outValid    (outValid),
    .outErr      (outErr),
    .outFrameErr (outFrameErr),
    .outBusy     (outBusy)
`ifdef FOUR_PARITY_RX_ERRCNT_EN
    ,
    .outErrCnt   (outErrCnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  always @(negedge clk) begin
    if (outValid === 1'b1) begin
      validCount++;
      lastValidCycle = cycleCnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    inS = b;
    repeat (4) tick();
  endtask

  // Leaves inS at the stop-bit level afterwards.
  task automatic sendFrame(input logic [3:0] d, input logic p, input logic s);
    frameStart = cycleCnt;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(d[i]);
    sendBit(p);
    sendBit(s);
  endtask

  int unsigned v0;
  int unsigned lat;
  logic sawBusy;

  initial begin
    // Reset state
    rst_n = 1'b0;
    inS = 1'b1;
    repeat (3) tick();
    check("rst_outData", 32'(outData), 32'h0);
    check("rst_outValid", 32'(outValid), 32'h0);
    check("rst_outErr", 32'(outErr), 32'h0);
    check("rst_outFrameErr", 32'(outFrameErr), 32'h0);
    check("rst_outBusy", 32'(outBusy), 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Good frame 1011, P=1
    v0 = validCount;
    sendFrame(4'b1011, 1'b1, 1'b1);
    inS = 1'b1;
    repeat (6) tick();
    lat = lastValidCycle - frameStart;
    check("good_validCount", validCount - v0, 32'd1);
    check("good_outData", 32'(outData), 32'hB);
    check("good_outErr", 32'(outErr), 32'h0);
    check("good_outFrameErr", 32'(outFrameErr), 32'h0);
    check("good_latency_28_to_30", 32'((lat >= 28) && (lat <= 30)), 32'h1);
    check("good_idle_busy", 32'(outBusy), 32'h0);

    // Parity error 0000, P=1
    v0 = validCount;
    sendFrame(4'b0000, 1'b1, 1'b1);
    inS = 1'b1;
    repeat (6) tick();
    check("par_validCount", validCount - v0, 32'd1);
    check("par_outData", 32'(outData), 32'h0);
    check("par_outErr", 32'(outErr), 32'h1);
    check("par_outFrameErr", 32'(outFrameErr), 32'h0);

    // Glitch: one cycle low
    v0 = validCount;
    sawBusy = 1'b0;
    inS = 1'b0;
    tick();
    inS = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (outBusy === 1'b1) sawBusy = 1'b1;
    end
    check("glitch_started", 32'(sawBusy), 32'h1);
    check("glitch_busy_cleared", 32'(outBusy), 32'h0);
    repeat (30) tick();
    check("glitch_no_valid", validCount - v0, 32'd0);
    check("glitch_hold_outErr", 32'(outErr), 32'h1);

    // Break: 0101, P=0, stop 0, held low
    v0 = validCount;
    sendFrame(4'b0101, 1'b0, 1'b0);
    repeat (40) tick();
    check("brk_validCount", validCount - v0, 32'd1);
    check("brk_outData", 32'(outData), 32'h5);
    check("brk_outErr", 32'(outErr), 32'h0);
    check("brk_outFrameErr", 32'(outFrameErr), 32'h1);
    check("brk_busy_while_low", 32'(outBusy), 32'h0);
    inS = 1'b1;
    repeat (8) tick();
    check("brk_no_retrigger", validCount - v0, 32'd1);
    sendFrame(4'b0110, 1'b0, 1'b1);
    inS = 1'b1;
    repeat (6) tick();
    check("brk_after_validCount", validCount - v0, 32'd2);
    check("brk_after_outData", 32'(outData), 32'h6);
    check("brk_after_outFrameErr", 32'(outFrameErr), 32'h0);

    // Bad parity to make outErr nonzero before the reset test
    sendFrame(4'b0001, 1'b0, 1'b1);
    inS = 1'b1;
    repeat (6) tick();
    check("pre_rst_outErr", 32'(outErr), 32'h1);

    // Reset mid-frame during DATA
    v0 = validCount;
    inS = 1'b0;
    repeat (4) tick();
    inS = 1'b1;
    repeat (4) tick();
    inS = 1'b0;
    repeat (2) tick();
    check("mid_busy_in_data", 32'(outBusy), 32'h1);
    rst_n = 1'b0;
    inS = 1'b1;
    repeat (2) tick();
    check("mid_outData", 32'(outData), 32'h0);
    check("mid_outErr", 32'(outErr), 32'h0);
    check("mid_outFrameErr", 32'(outFrameErr), 32'h0);
    check("mid_outValid", 32'(outValid), 32'h0);
    check("mid_outBusy", 32'(outBusy), 32'h0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("mid_no_valid", validCount - v0, 32'd0);
    sendFrame(4'b1100, 1'b0, 1'b1);
    inS = 1'b1;
    repeat (6) tick();
    lat = lastValidCycle - frameStart;
    check("post_validCount", validCount - v0, 32'd1);
    check("post_outData", 32'(outData), 32'hC);
    check("post_outErr", 32'(outErr), 32'h0);
    check("post_outFrameErr", 32'(outFrameErr), 32'h0);
    check("post_latency_28_to_30", 32'((lat >= 28) && (lat <= 30)), 32'h1);

`ifdef FOUR_PARITY_RX_ERRCNT_EN
    // Saturating error counter
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("cnt_reset", 32'(outErrCnt), 32'h0);
    for (int i = 0; i < 260; i++) begin
      sendFrame(4'b0000, 1'b1, 1'b1);
      inS = 1'b1;
      repeat (4) tick();
      if (i == 0) check("cnt_first", 32'(outErrCnt), 32'd1);
    end
    check("cnt_saturated", 32'(outErrCnt), 32'd255);
    sendFrame(4'b1011, 1'b1, 1'b1);
    inS = 1'b1;
    repeat (6) tick();
    check("cnt_good_frame_hold", 32'(outErrCnt), 32'd255);
    check("cnt_good_frame_data", 32'(outData), 32'hB);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/four_parity_rx.md
FOUR_PARITY_RX -- requirements
Module: four_parity_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; the block SHALL require an even value of at least 2.
REQ-002 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port inS  input  1  serial line; idles high.
REQ-005 Port outData  output  4  last received data nibble.
REQ-006 Port outValid  output  1  one-cycle pulse marking a completed frame.
REQ-007 Port outErr  output  1  parity error for the frame marked by outValid.
REQ-008 Port outFrameErr  output  1  stop-bit error for the frame marked by outValid.
REQ-009 Port outBusy  output  1  high while a frame is in progress.

Function
REQ-010 The frame SHALL be: start bit 0; data bits D0..D3, LSB first; even-parity bit P; stop bit 1. A frame is good when D0^D1^D2^D3^P == 0.
REQ-011 inS SHALL pass through a 2-flop synchronizer; all timing below refers to the synchronized signal inS_s.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-013 IDLE: when armed and inS_s==0, go to START and load the bit timer with CLKS_PER_BIT/2-1.
REQ-014 START: on timer expiry, resample inS_s. If it is 1 (glitch), return to IDLE with no output. Otherwise go to DATA with the timer at CLKS_PER_BIT-1.
REQ-015 DATA: sample one bit per timer expiry (mid-bit) into a shift register. After 4 samples, go to PARITY.
REQ-016 PARITY: sample P on timer expiry, then go to STOP.
REQ-017 STOP: on timer expiry, sample the stop bit and return to IDLE. On the next cycle, outValid=1 for exactly one cycle; outData, outErr and outFrameErr update in that same cycle.
REQ-018 outData, outErr and outFrameErr SHALL hold their values until the next outValid pulse.
REQ-019 outErr SHALL be computed from the sampled D0..D3 and P. outFrameErr SHALL be 1 when the sampled stop bit is 0. Both may be 1 together.
REQ-020 Armed flag: cleared when outFrameErr is set; set when inS_s is sampled at 1 in IDLE. This prevents a held-low line (break) from retriggering frames.
REQ-021 outBusy SHALL be 1 in every state except IDLE.
REQ-022 The bit timer SHALL count down to 0 and reload; expiry is the cycle in which the count is 0.

Reset
REQ-023 When rst_n==0 at a clock edge: FSM=IDLE; armed=1; outData=0; outValid=0; outErr=0; outFrameErr=0; outBusy=0; timer=0; shift register=0; synchronizer flops=1.
REQ-024 Reset mid-frame SHALL discard the partial frame, with no outValid pulse.

Configuration
REQ-025 With macro FOUR_PARITY_RX_ERRCNT_EN defined, the block SHALL add port outErrCnt  output  8. This is a saturating count (max 255) of frames with outErr or outFrameErr set, incremented in the outValid cycle and reset to 0.
REQ-026 Without FOUR_PARITY_RX_ERRCNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-027 Package four_parity_pkg SHALL hold the FSM state enum, the DATA_BITS=4 constant and the parity-compute function, for sharing with the transmit side.
REQ-028 The bit timer SHALL be one sub-module, bit_timer (load value, count down, expiry output); no other sub-modules.

Verification (CLKS_PER_BIT=4)
REQ-029 Good frame: data 4'b1011, P=1, stop 1 -> one outValid pulse with outData=4'b1011, outErr=0, outFrameErr=0; outValid rises 2 (sync) + 2 (start) + 24 (6 bits) + 1 = 29 cycles after the inS falling edge, within ±1.
REQ-030 Parity error: data 4'b0000, P=1 -> outData=4'b0000, outErr=1, outFrameErr=0.
REQ-031 Break: data 4'b0101, P=0, stop 0, line held low for 40 cycles -> one outValid with outFrameErr=1; no further outValid until inS returns high and a new start bit arrives.
REQ-032 Glitch: inS low for 1 cycle only -> no outValid; outBusy returns to 0 within 6 cycles.
REQ-033 Reset mid-frame: rst_n=0 during DATA -> outputs at their reset values, no outValid; the next good frame 4'b1100 with P=0 is received correctly.
REQ-034 Error count (FOUR_PARITY_RX_ERRCNT_EN defined): 260 bad-parity frames -> outErrCnt=255; a following good frame leaves it at 255.
